forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand data width.
REQ-002 SHALL have parameter NUM_SRC, default 2: source operands per instruction.
REQ-003 SHALL have parameter NUM_FWD_STAGES, default 2: post-EX stages that can forward (1 = EX/MEM, 2 = MEM/WB, ...).
REQ-004 SHALL have parameter LOAD_LAT, default 1: a load result is forwardable only from stage k > LOAD_LAT; legal range 1..NUM_FWD_STAGES-1.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_regwrite  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination.
- ex_rs  in  NUM_SRC*5  EX source addresses, packed, src0 in LSBs.
- id_rs  in  NUM_SRC*5  ID source addresses.
- id_rs_used  in  NUM_SRC  per-source read-enable in ID.
- rf_data  in  NUM_SRC*XLEN  register-file read data for EX sources.
- stage_data  in  NUM_FWD_STAGES*XLEN  result of stage k in slice k-1.
- flush  in  1  kill ID and EX this cycle.
- stat_clr  in  1  synchronous clear of stall_cnt.
- ex_opnd  out  NUM_SRC*XLEN  forwarded operands.
- ex_fwd_sel  out  NUM_SRC*$clog2(NUM_FWD_STAGES+1)  0 = register file, k = stage k.
- id_stall  out  1  hold PC/ID, insert bubble into EX.
- stall_cnt  out  16  saturating stall-cycle count.
- hazard_err  out  1  sticky: EX sourced an unready load.

Function
REQ-006 SHALL keep a tag tracker of NUM_FWD_STAGES entries {valid, wen, is_load, rd}; each clk, entry k+1 takes entry k and entry 1 takes the EX tag; valid = ex_valid & ~flush.
REQ-007 SHALL treat an entry as a producer only if valid, wen and rd != 0.
REQ-008 SHALL select ex_fwd_sel per source as the smallest k whose producer rd equals ex_rs; 0 if none (youngest wins).
REQ-009 SHALL drive ex_opnd combinationally: stage_data slice k-1 for sel k, else rf_data; zero-cycle latency.
REQ-010 SHALL raise id_stall when a used ID source matches a load producer at position p < LOAD_LAT (EX = position 0, entry k = position k), and no younger producer at position < p writes the same rd.
REQ-011 SHALL force id_stall to 0 while flush = 1 or rst = 1.
REQ-012 SHALL need no stall state: repeated stalls follow from the tracker advancing behind an injected bubble; LOAD_LAT = 2 with an adjacent dependency yields exactly 2 stall cycles.
REQ-013 SHALL set hazard_err when any EX source selects entry k <= LOAD_LAT holding a load; it stays set until reset.
REQ-014 SHALL increment stall_cnt each cycle id_stall = 1, saturating at 16'hFFFF; stat_clr has priority and loads 0.
REQ-015 SHALL never forward or stall for register x0, including when several entries carry rd = 0.

Reset
REQ-016 SHALL, on rst assertion, immediately clear all tracker valid bits, stall_cnt and hazard_err; all ex_fwd_sel = 0 and id_stall = 0 during reset.
REQ-017 SHALL, after reset deassertion mid-stream, produce no forwarding from instructions issued before reset.

Structure
REQ-018 SHALL place the tracker entry typedef and the select-width function in the shared pipeline package.
REQ-019 SHALL implement per-source select and mux as one sub-module, fwd_src_select, instantiated NUM_SRC times.

Verification
REQ-020 SHALL cover: add x5 in EX, next instruction reads x5 in EX -> sel 1, ex_opnd = stage_data[0].
REQ-021 SHALL cover: x5 written at stages 1 and 2 -> sel 1 (youngest); only stage 2 -> sel 2.
REQ-022 SHALL cover: lw x7 in EX, ID reads x7, LOAD_LAT = 1 -> id_stall 1 for one cycle, then sel 2, stall_cnt = 1.
REQ-023 SHALL cover: same as REQ-022 with flush = 1 -> id_stall 0, next-cycle entry 1 invalid.
REQ-024 SHALL cover: EX writes x0, ID reads x0 -> sel 0, no stall; forced unready-load EX read -> hazard_err = 1.
REQ-025 SHALL cover: stall_cnt at 16'hFFFF with stall -> holds; rst mid-stall -> all outputs and counters 0 at once.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding / hazard unit: the tag
// carried down the post-EX tracker and helpers used by the top and by the
// per-source select.
package forward_hazard_unit_pkg;

  localparam int REG_AW = 5;

  // One tracker slot: what the instruction now sitting in that stage will write.
  typedef struct packed {
    logic              valid;
    logic              wen;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } trk_entry_t;

  // Width of a forwarding select: 0 = register file, 1..num_stages = stage k.
  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // x0 is never a producer, no matter how many entries carry rd = 0.
  function automatic logic is_producer(input trk_entry_t e);
    return e.valid & e.wen & (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Per-source operand select: picks the youngest post-EX producer of rs and
// muxes its stage result, falling back to the register-file read data.
module fwd_src_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1,
  localparam int SelW          = sel_width(NUM_FWD_STAGES)
) (
  input  logic [REG_AW-1:0]                      rs_i,
  input  trk_entry_t [NUM_FWD_STAGES-1:0]        trk_i,
  input  logic [XLEN-1:0]                        rf_data_i,
  input  logic [NUM_FWD_STAGES*XLEN-1:0]         stage_data_i,
  output logic [SelW-1:0]                        sel_o,
  output logic [XLEN-1:0]                        opnd_o,
  output logic                                   unready_load_o
);

  // Scan oldest to youngest so the smallest matching stage wins.
  always_comb begin
    sel_o          = '0;
    opnd_o         = rf_data_i;
    unready_load_o = 1'b0;
    for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
      if (is_producer(trk_i[k-1]) && (trk_i[k-1].rd == rs_i)) begin
        sel_o          = SelW'(k);
        opnd_o         = stage_data_i[(k-1)*XLEN +: XLEN];
        unready_load_o = (k <= LOAD_LAT) && trk_i[k-1].is_load;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use hazard detection. A shift register of
// destination tags follows each EX instruction through the forwarding
// stages; forwarding and stall decisions are pure functions of that tracker
// plus the current EX tag, so no separate stall state is needed.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          ex_valid,
  input  logic                                          ex_regwrite,
  input  logic                                          ex_is_load,
  input  logic [4:0]                                    ex_rd,
  input  logic [NUM_SRC*5-1:0]                          ex_rs,
  input  logic [NUM_SRC*5-1:0]                          id_rs,
  input  logic [NUM_SRC-1:0]                            id_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]                       rf_data,
  input  logic [NUM_FWD_STAGES*XLEN-1:0]                stage_data,
  input  logic                                          flush,
  input  logic                                          stat_clr,
  output logic [NUM_SRC*XLEN-1:0]                       ex_opnd,
  output logic [NUM_SRC*$clog2(NUM_FWD_STAGES+1)-1:0]   ex_fwd_sel,
  output logic                                          id_stall,
  output logic [15:0]                                   stall_cnt,
  output logic                                          hazard_err
);

  localparam int SelW = sel_width(NUM_FWD_STAGES);

  trk_entry_t                        ex_tag;
  trk_entry_t [NUM_FWD_STAGES-1:0]   trk_q, trk_d;
  trk_entry_t [NUM_FWD_STAGES:0]     pos_tag;
  logic [NUM_SRC-1:0]                unready_src;
  logic [NUM_SRC-1:0]                src_load_hit;
  logic                              stall_raw;
  logic [15:0]                       stall_cnt_q, stall_cnt_d;
  logic                              hazard_err_q, hazard_err_d;

  // A flushed EX instruction enters the tracker as a bubble.
  assign ex_tag.valid   = ex_valid & ~flush;
  assign ex_tag.wen     = ex_regwrite;
  assign ex_tag.is_load = ex_is_load;
  assign ex_tag.rd      = ex_rd;

  // Position 0 is EX itself, position k is tracker entry k.
  assign pos_tag = {trk_q, ex_tag};

  // Tracker shifts one stage per cycle, EX tag enters at entry 1.
  always_comb begin
    trk_d    = trk_q;
    trk_d[0] = ex_tag;
    for (int k = 1; k < NUM_FWD_STAGES; k++) begin
      trk_d[k] = trk_q[k-1];
    end
  end

  // Tracker register; reset drops every in-flight producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trk_q <= '0;
    else     trk_q <= trk_d;
  end

  // Per source: forwarding select, operand mux and unready-load detection.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_select #(
      .XLEN           (XLEN),
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .LOAD_LAT       (LOAD_LAT)
    ) u_sel (
      .rs_i           (ex_rs[s*5 +: 5]),
      .trk_i          (trk_q),
      .rf_data_i      (rf_data[s*XLEN +: XLEN]),
      .stage_data_i   (stage_data),
      .sel_o          (ex_fwd_sel[s*SelW +: SelW]),
      .opnd_o         (ex_opnd[s*XLEN +: XLEN]),
      .unready_load_o (unready_src[s])
    );
  end

  // Load-use check: the youngest matching producer in the not-yet-ready
  // window decides; a younger ALU write of the same rd hides an older load.
  always_comb begin
    src_load_hit = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used[s]) begin
        for (int p = LOAD_LAT - 1; p >= 0; p--) begin
          if (is_producer(pos_tag[p]) && (pos_tag[p].rd == id_rs[s*5 +: 5])) begin
            src_load_hit[s] = pos_tag[p].is_load;
          end
        end
      end
    end
    stall_raw = |src_load_hit;
  end

  assign id_stall = stall_raw & ~flush & ~rst;

  // Stall statistics and sticky error next-state; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)                               stall_cnt_d = '0;
    else if (id_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    hazard_err_d = hazard_err_q | (|unready_src);
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit with default parameters
// (XLEN 32, two sources, two forwarding stages, LOAD_LAT 1).
module tb_forward_hazard_unit;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;
  localparam logic [31:0] S1  = 32'h1111_1111;
  localparam logic [31:0] S2  = 32'h2222_2222;

  logic        clk, rst;
  logic        ex_valid, ex_regwrite, ex_is_load;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_rs, id_rs;
  logic [1:0]  id_rs_used;
  logic [63:0] rf_data, stage_data;
  logic        flush, stat_clr;
  logic [63:0] ex_opnd;
  logic [3:0]  ex_fwd_sel;
  logic        id_stall;
  logic [15:0] stall_cnt;
  logic        hazard_err;

  int n_chk  = 0;
  int n_fail = 0;

  forward_hazard_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_regwrite(ex_regwrite),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_rs      (ex_rs),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .rf_data    (rf_data),
    .stage_data (stage_data),
    .flush      (flush),
    .stat_clr   (stat_clr),
    .ex_opnd    (ex_opnd),
    .ex_fwd_sel (ex_fwd_sel),
    .id_stall   (id_stall),
    .stall_cnt  (stall_cnt),
    .hazard_err (hazard_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic w, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs0, input logic [4:0] rs1);
    ex_valid = v; ex_regwrite = w; ex_is_load = ld; ex_rd = rd;
    ex_rs = {rs1, rs0};
  endtask

  task automatic set_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    id_rs = {rs1, rs0};
    id_rs_used = used;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stat_clr = 1'b0;
    rf_data    = {RF1, RF0};
    stage_data = {S2, S1};
    // reset with a would-be load-use pair presented
    set_ex(1, 1, 1, 5'd5, 5'd5, 5'd0);
    set_id(5'd5, 5'd0, 2'b01);
    #2;
    chk("rst_stall", {31'd0, id_stall}, 32'd0);
    chk("rst_sel", {28'd0, ex_fwd_sel}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_herr", {31'd0, hazard_err}, 32'd0);
    chk("rst_opnd0", ex_opnd[31:0], RF0);
    tick();
    chk("rst_cnt_held", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;

    // T1: add x5 in EX; ID reads x5 but EX is not a load
    set_ex(1, 1, 0, 5'd5, 5'd1, 5'd2); set_id(5'd5, 5'd0, 2'b01); #1;
    chk("t1_alu_nostall", {31'd0, id_stall}, 32'd0);
    tick();
    // T2: reads x5 produced one stage ahead; also writes x5
    set_ex(1, 1, 0, 5'd5, 5'd5, 5'd3); set_id(5'd0, 5'd0, 2'b00); #1;
    chk("t2_sel0", {30'd0, ex_fwd_sel[1:0]}, 32'd1);
    chk("t2_opnd0", ex_opnd[31:0], S1);
    chk("t2_sel1", {30'd0, ex_fwd_sel[3:2]}, 32'd0);
    chk("t2_opnd1", ex_opnd[63:32], RF1);
    tick();
    // T3: x5 at stages 1 and 2 -> youngest; EX writes x0
    set_ex(1, 1, 0, 5'd0, 5'd5, 5'd0); #1;
    chk("t3_youngest_sel", {30'd0, ex_fwd_sel[1:0]}, 32'd1);
    chk("t3_youngest_opnd", ex_opnd[31:0], S1);
    tick();
    // T4: x5 only at stage 2, x0 at stage 1; EX is lw x0, ID reads x0
    set_ex(1, 1, 1, 5'd0, 5'd5, 5'd0); set_id(5'd0, 5'd0, 2'b01); #1;
    chk("t4_stage2_sel", {28'd0, ex_fwd_sel}, 32'd2);
    chk("t4_stage2_opnd", ex_opnd[31:0], S2);
    chk("t4_x0_nostall", {31'd0, id_stall}, 32'd0);
    tick();
    // T5: EX reads x0 (entries carry rd 0); lw x7 in EX, ID reads x7
    set_ex(1, 1, 1, 5'd7, 5'd0, 5'd0); set_id(5'd7, 5'd0, 2'b01); #1;
    chk("t5_x0_sel", {28'd0, ex_fwd_sel}, 32'd0);
    chk("t5_loaduse_stall", {31'd0, id_stall}, 32'd1);
    chk("t5_cnt_before", {16'd0, stall_cnt}, 32'd0);
    tick();
    // T6: bubble in EX, load now at entry 1 -> stall released
    set_ex(0, 0, 0, 5'd0, 5'd0, 5'd0); #1;
    chk("t6_stall_released", {31'd0, id_stall}, 32'd0);
    chk("t6_cnt", {16'd0, stall_cnt}, 32'd1);
    tick();
    // T7: dependent instruction in EX picks the load from stage 2
    set_ex(1, 1, 0, 5'd8, 5'd7, 5'd0); set_id(5'd0, 5'd0, 2'b00); #1;
    chk("t7_load_sel", {28'd0, ex_fwd_sel}, 32'd2);
    chk("t7_load_opnd", ex_opnd[31:0], S2);
    chk("t7_herr", {31'd0, hazard_err}, 32'd0);
    tick();
    // T8: same load-use pair under flush
    set_ex(1, 1, 1, 5'd9, 5'd0, 5'd0); set_id(5'd9, 5'd0, 2'b01); flush = 1'b1; #1;
    chk("t8_flush_nostall", {31'd0, id_stall}, 32'd0);
    tick();
    // T9: entry 1 must be invalid (no x9 forward); x8 still at stage 2
    flush = 1'b0;
    set_ex(1, 1, 0, 5'd10, 5'd9, 5'd8); set_id(5'd0, 5'd0, 2'b00); #1;
    chk("t9_flushed_entry", {28'd0, ex_fwd_sel}, 32'h8);
    chk("t9_opnd0_rf", ex_opnd[31:0], RF0);
    chk("t9_cnt", {16'd0, stall_cnt}, 32'd1);
    tick();
    // T10/T11: force EX to source an unready load from entry 1
    set_ex(1, 1, 1, 5'd11, 5'd0, 5'd0); #1;
    chk("t10_herr_clear", {31'd0, hazard_err}, 32'd0);
    tick();
    set_ex(1, 1, 0, 5'd12, 5'd11, 5'd0); #1;
    chk("t11_unready_sel", {28'd0, ex_fwd_sel}, 32'd1);
    tick();
    chk("t12_herr_set", {31'd0, hazard_err}, 32'd1);
    // T12: clear while stalling -> clear wins
    stat_clr = 1'b1;
    set_ex(1, 1, 1, 5'd7, 5'd0, 5'd0); set_id(5'd7, 5'd0, 2'b01); #1;
    chk("t12_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("t12_clr_priority", {16'd0, stall_cnt}, 32'd0);
    stat_clr = 1'b0;
    // sustained stall up to saturation
    repeat (65534) tick();
    chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
    tick();
    chk("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("herr_sticky", {31'd0, hazard_err}, 32'd1);
    // reset mid-stall with a live forward
    set_ex(1, 1, 1, 5'd7, 5'd7, 5'd0); #1;
    chk("pre_rst_sel", {28'd0, ex_fwd_sel}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_stall", {31'd0, id_stall}, 32'd0);
    chk("mid_rst_sel", {28'd0, ex_fwd_sel}, 32'd0);
    chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_herr", {31'd0, hazard_err}, 32'd0);
    tick();
    rst = 1'b0;
    set_ex(0, 0, 0, 5'd0, 5'd7, 5'd0); set_id(5'd0, 5'd0, 2'b00); #1;
    chk("post_rst_sel", {28'd0, ex_fwd_sel}, 32'd0);
    tick();
    chk("post_rst_sel2", {28'd0, ex_fwd_sel}, 32'd0);
    chk("post_rst_cnt", {16'd0, stall_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
